// File: rtl/byte_packer.sv
// Byte packer: gathers a stream of bytes into NBYTES-wide words, lowest lane first.
// A word is emitted when it fills or when a byte marked last arrives, so short
// packet tails come out as partial words with a matching keep mask.
module byte_packer #(
    parameter int NBYTES = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  valid_i,
    input  logic [7:0]            din,
    input  logic                  last_i,
    output logic                  ready_o,
    output logic                  valid_o,
    output logic [8*NBYTES-1:0]   dout,
    output logic [NBYTES-1:0]     keep_o,
    output logic                  last_o,
    input  logic                  ready_i
);

    localparam int CW = $clog2(NBYTES);

    logic [CW-1:0]          cnt;
    logic [8*NBYTES-1:0]    acc_data;
    logic [NBYTES-1:0]      acc_keep;
    logic                   accept;
    logic                   complete;
    logic [8*NBYTES-1:0]    merged_data;
    logic [NBYTES-1:0]      merged_keep;

    // The single output register can take a new word whenever it is empty or
    // being drained this cycle, so upstream never stalls on a draining word.
    assign ready_o  = ~valid_o | ready_i;
    assign accept   = valid_i & ready_o;
    assign complete = accept & (last_i | (cnt == CW'(NBYTES - 1)));

    // Partial word with the incoming byte dropped into lane cnt.
    always_comb begin
        merged_data = acc_data;
        merged_keep = acc_keep;
        for (int k = 0; k < NBYTES; k++) begin
            if (cnt == CW'(k)) begin
                merged_data[8*k +: 8] = din;
                merged_keep[k]        = 1'b1;
            end
        end
    end

    // Accumulator: grows by one lane per accepted byte, empties when a word completes.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt      <= '0;
            acc_data <= '0;
            acc_keep <= '0;
        end else if (complete) begin
            cnt      <= '0;
            acc_data <= '0;
            acc_keep <= '0;
        end else if (accept) begin
            cnt      <= cnt + 1'b1;
            acc_data <= merged_data;
            acc_keep <= merged_keep;
        end
    end

    // Output register: a completing byte overwrites it (no bubble), a drain alone clears valid.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_o <= 1'b0;
            dout    <= '0;
            keep_o  <= '0;
            last_o  <= 1'b0;
        end else if (complete) begin
            valid_o <= 1'b1;
            dout    <= merged_data;
            keep_o  <= merged_keep;
            last_o  <= last_i;
        end else if (valid_o && ready_i) begin
            valid_o <= 1'b0;
        end
    end

endmodule

// File: tb/tb_byte_packer.sv
// Testbench for byte_packer: directed scenarios plus random traffic, all checked
// cycle by cycle against a queue-based packing model.
module tb_byte_packer;

    localparam int NBYTES = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid_i;
    logic [7:0]  din;
    logic        last_i;
    logic        ready_o;
    logic        valid_o;
    logic [31:0] dout;
    logic [3:0]  keep_o;
    logic        last_o;
    logic        ready_i;

    int checks   = 0;
    int failures = 0;

    logic [7:0]  part_q[$];
    logic        exp_valid;
    logic [31:0] exp_word;
    logic [3:0]  exp_keep;
    logic        exp_last;

    byte_packer #(.NBYTES(NBYTES)) dut (
        .clk     (clk),
        .rst     (rst),
        .valid_i (valid_i),
        .din     (din),
        .last_i  (last_i),
        .ready_o (ready_o),
        .valid_o (valid_o),
        .dout    (dout),
        .keep_o  (keep_o),
        .last_o  (last_o),
        .ready_i (ready_i)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=0x%0h expected=0x%0h at %0t", tag, actual, expected, $time);
        end
    endtask

    task automatic modelClear();
        part_q.delete();
        exp_valid = 1'b0;
        exp_word  = '0;
        exp_keep  = '0;
        exp_last  = 1'b0;
    endtask

    // One clock edge of the packing rules: collect bytes, emit a word when full or last.
    task automatic modelStep(input logic v, input logic [7:0] d, input logic l, input logic r);
        logic rdy;
        logic done;
        rdy  = !exp_valid || r;
        done = 1'b0;
        if (v && rdy) begin
            part_q.push_back(d);
            if (part_q.size() == NBYTES || l) begin
                exp_word = '0;
                foreach (part_q[i]) exp_word |= 32'(part_q[i]) << (8 * i);
                exp_keep  = 4'((1 << part_q.size()) - 1);
                exp_last  = l;
                exp_valid = 1'b1;
                part_q.delete();
                done = 1'b1;
            end
        end
        if (!done && exp_valid && r) exp_valid = 1'b0;
    endtask

    // Drive one cycle of inputs, compare outputs against the model, then advance the model.
    task automatic applyStimulus(input logic v, input logic [7:0] d, input logic l, input logic r);
        @(negedge clk);
        valid_i = v;
        din     = d;
        last_i  = l;
        ready_i = r;
        #1;
        checkOutput("ready_o", 32'(ready_o), 32'(!exp_valid || r));
        checkOutput("valid_o", 32'(valid_o), 32'(exp_valid));
        if (exp_valid) begin
            checkOutput("dout", dout, exp_word);
            checkOutput("keep_o", 32'(keep_o), 32'(exp_keep));
            checkOutput("last_o", 32'(last_o), 32'(exp_last));
        end
        @(posedge clk);
        if (rst) modelStep(v, d, l, r);
    endtask

    // Assert reset mid-cycle, confirm outputs clear without a clock edge, then release.
    task automatic resetPulse(input int cycles);
        @(negedge clk);
        valid_i = 1'b0;
        rst     = 1'b0;
        #1;
        checkOutput("rst_valid_o", 32'(valid_o), 32'd0);
        checkOutput("rst_dout", dout, 32'd0);
        checkOutput("rst_keep_o", 32'(keep_o), 32'd0);
        checkOutput("rst_last_o", 32'(last_o), 32'd0);
        checkOutput("rst_ready_o", 32'(ready_o), 32'd1);
        modelClear();
        repeat (cycles) @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        rst     = 1'b1;
        valid_i = 1'b0;
        din     = 8'h00;
        last_i  = 1'b0;
        ready_i = 1'b1;
        modelClear();
        resetPulse(2);

        // Four full bytes form one word.
        applyStimulus(1'b1, 8'h11, 1'b0, 1'b1);
        applyStimulus(1'b1, 8'h22, 1'b0, 1'b1);
        applyStimulus(1'b1, 8'h33, 1'b0, 1'b1);
        applyStimulus(1'b1, 8'h44, 1'b0, 1'b1);
        #1;
        checkOutput("full_valid", 32'(valid_o), 32'd1);
        checkOutput("full_dout", dout, 32'h44332211);
        checkOutput("full_keep", 32'(keep_o), 32'hF);
        checkOutput("full_last", 32'(last_o), 32'd0);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);

        // Two-byte packet tail, then a one-byte packet landing in lane 0.
        applyStimulus(1'b1, 8'hAA, 1'b0, 1'b1);
        applyStimulus(1'b1, 8'hBB, 1'b1, 1'b1);
        #1;
        checkOutput("short_dout", dout, 32'h0000BBAA);
        checkOutput("short_keep", 32'(keep_o), 32'h3);
        checkOutput("short_last", 32'(last_o), 32'd1);
        applyStimulus(1'b1, 8'h5A, 1'b1, 1'b1);
        #1;
        checkOutput("single_valid", 32'(valid_o), 32'd1);
        checkOutput("single_dout", dout, 32'h0000005A);
        checkOutput("single_keep", 32'(keep_o), 32'h1);
        checkOutput("single_last", 32'(last_o), 32'd1);

        // Continuous 12-byte stream with the sink always ready.
        for (int i = 1; i <= 12; i++) applyStimulus(1'b1, 8'(i), 1'b0, 1'b1);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);

        // Backpressure: first word held while byte 5 waits upstream.
        for (int i = 1; i <= 4; i++) applyStimulus(1'b1, 8'(i), 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 8'h05, 1'b0, 1'b0);
            #1;
            checkOutput("stall_ready_o", 32'(ready_o), 32'd0);
            checkOutput("stall_dout", dout, 32'h04030201);
            checkOutput("stall_keep", 32'(keep_o), 32'hF);
        end
        for (int i = 5; i <= 8; i++) applyStimulus(1'b1, 8'(i), 1'b0, 1'b1);
        #1;
        checkOutput("resume_dout", dout, 32'h08070605);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);

        // Reset with a word pending, then with a partial word, then a clean word.
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, 8'(8'hC1 + i), 1'b0, 1'b0);
        resetPulse(1);
        applyStimulus(1'b1, 8'hE1, 1'b0, 1'b1);
        applyStimulus(1'b1, 8'hE2, 1'b0, 1'b1);
        resetPulse(1);
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, 8'(8'h10 + i), 1'b0, 1'b1);
        #1;
        checkOutput("post_rst_dout", dout, 32'h13121110);
        checkOutput("post_rst_keep", 32'(keep_o), 32'hF);

        // Random traffic with occasional resets.
        for (int n = 0; n < 800; n++) begin
            if ($urandom_range(0, 99) == 0) begin
                resetPulse(1);
            end else begin
                applyStimulus($urandom_range(0, 99) < 70,
                              8'($urandom_range(0, 255)),
                              $urandom_range(0, 99) < 20,
                              $urandom_range(0, 99) < 70);
            end
        end
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
